game_input_conditioner: RTL and testbench

Front-end conditioning stage that sits directly upstream of the game top-level FSM (start/math/mole/finish). It synchronises the raw board switches and active-low pushbuttons to clk, debounces the buttons into clean one-cycle press pulses, and reports per-switch flip events for the mole round. It also generates the 1-second tick that drives the countdown display, so the game FSM no longer runs its own 50M-cycle counter.

---
 rtl/game_pkg.sv | 22 ++
 rtl/button_debouncer.sv | 98 +++++++++
 rtl/game_input_conditioner.sv | 112 +++++++++++
 tb/tb_game_input_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the game front end.
//   CLK_HZ          system clock frequency in Hz
//   NUM_SW_DEFAULT  number of slide switches on the board
//   DEBOUNCE_MS     button settle time in milliseconds
//   debounce_state_t  per-button debouncer state
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int CLK_HZ         = 50000000;
    localparam int NUM_SW_DEFAULT = 10;
    localparam int DEBOUNCE_MS    = 20;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } debounce_state_t;

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Two-flop synchroniser, four-state debounce FSM and registered press pulse
// for one active-low pushbutton.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active-low
//   btn_n  in   raw button, asynchronous, 0 = pressed
//   level  out  debounced level, 1 = held (DOWN or WAIT_UP)
//   press  out  one-cycle pulse, one cycle after an accepted press
// -----------------------------------------------------------------------------
module button_debouncer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync_out;
    logic            pressed;
    logic            went_down;
    logic [CW-1:0]   cnt;
    debounce_state_t state;

    assign pressed = ~sync_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            state     <= UP;
            cnt       <= '0;
            level     <= 1'b0;
            went_down <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync_meta <= btn_n;
            sync_out  <= sync_meta;
            // The pulse trails the WAIT_DOWN->DOWN transition by one cycle.
            press     <= went_down;
            went_down <= 1'b0;
            case (state)
                UP: begin
                    if (pressed) begin
                        state <= WAIT_DOWN;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_DOWN: begin
                    if (!pressed) begin
                        state <= UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DOWN;
                        cnt       <= '0;
                        level     <= 1'b1;
                        went_down <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DOWN: begin
                    if (!pressed) begin
                        state <= WAIT_UP;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_UP: begin
                    if (pressed) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= UP;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= UP;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/game_input_conditioner.sv
// -----------------------------------------------------------------------------
// game_input_conditioner
// Front-end conditioning for the game FSM: debounced button pulses,
// synchronised switches with per-cycle change mask, and a periodic tick.
// Ports:
//   clk          in   system clock, 50 MHz
//   rst_n        in   synchronous reset, active-low
//   btn_enter_n  in   raw enter button, 0 = pressed
//   btn_reset_n  in   raw reset button, 0 = pressed
//   sw_raw       in   raw slide switches
//   tick_clr     in   restart the tick period
//   enter_level  out  debounced enter state, 1 = held
//   enter_press  out  one-cycle pulse per accepted enter press
//   reset_press  out  one-cycle pulse per accepted reset press
//   sw_sync      out  synchronised switch levels
//   sw_delta     out  one-cycle mask of switches that changed
//   sec_tick     out  one-cycle pulse every TICK_CYCLES cycles
// -----------------------------------------------------------------------------
module game_input_conditioner
    import game_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS,
    parameter int TICK_CYCLES     = CLK_HZ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_enter_n,
    input  logic              btn_reset_n,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              tick_clr,
    output logic              enter_level,
    output logic              enter_press,
    output logic              reset_press,
    output logic [NUM_SW-1:0] sw_sync,
    output logic [NUM_SW-1:0] sw_delta,
    output logic              sec_tick
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [NUM_SW-1:0] sw_meta;
    logic [NUM_SW-1:0] sw_prev;
    logic [1:0]        fill;
    logic [TW-1:0]     tick_cnt;
    logic [TW-1:0]     tick_next;
    logic              reset_level_unused;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_enter_n),
        .level (enter_level),
        .press (enter_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_reset (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_reset_n),
        .level (reset_level_unused),
        .press (reset_press)
    );

    // Switch synchroniser and registered change mask. The mask is held at
    // zero for three cycles after reset so switches already on at power-up
    // do not report a flip.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            sw_prev  <= '0;
            sw_delta <= '0;
            fill     <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (fill == 2'd3) begin
                sw_delta <= sw_sync ^ sw_prev;
            end else begin
                sw_delta <= '0;
                fill     <= fill + 2'd1;
            end
        end
    end

    always_comb begin
        tick_next = tick_cnt + TW'(1);
        if (tick_clr || (tick_cnt == TICK_LAST)) begin
            tick_next = '0;
        end
    end

    // sec_tick is registered from the next count so it is high exactly
    // while tick_cnt holds the terminal value; a clear forces next to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sec_tick <= 1'b0;
        end else begin
            tick_cnt <= tick_next;
            sec_tick <= (tick_next == TICK_LAST);
        end
    end

endmodule

// File: tb/tb_game_input_conditioner.sv
module tb_game_input_conditioner;

    localparam int K_ENTER = 0;
    localparam int K_RESET = 1;
    localparam int K_LEVEL = 2;
    localparam int K_SYNC  = 3;
    localparam int K_DELTA = 4;
    localparam int K_TICK  = 5;

    typedef struct {
        int         kind;
        int         cyc;
        logic [9:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_enter_n;
    logic       btn_reset_n;
    logic [9:0] sw_raw;
    logic       tick_clr;
    logic       enter_level;
    logic       enter_press;
    logic       reset_press;
    logic [9:0] sw_sync;
    logic [9:0] sw_delta;
    logic       sec_tick;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic       prev_level;
    logic [9:0] prev_sync;
    logic [9:0] sw_model = '0;
    ev_t        expq[$];

    game_input_conditioner #(
        .NUM_SW          (10),
        .DEBOUNCE_CYCLES (4),
        .TICK_CYCLES     (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_enter_n (btn_enter_n),
        .btn_reset_n (btn_reset_n),
        .sw_raw      (sw_raw),
        .tick_clr    (tick_clr),
        .enter_level (enter_level),
        .enter_press (enter_press),
        .reset_press (reset_press),
        .sw_sync     (sw_sync),
        .sw_delta    (sw_delta),
        .sec_tick    (sec_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            K_ENTER: return "enter_press";
            K_RESET: return "reset_press";
            K_LEVEL: return "enter_level";
            K_SYNC:  return "sw_sync";
            K_DELTA: return "sw_delta";
            default: return "sec_tick";
        endcase
    endfunction

    task automatic push(input int kind, input int c, input logic [9:0] v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        expq.push_back(e);
    endtask

    // Pop the oldest expected event of this kind and compare time and value.
    task automatic observe(input int kind, input logic [9:0] val);
        int idx;
        idx = -1;
        checks++;
        foreach (expq[i]) begin
            if (idx < 0 && expq[i].kind == kind) idx = i;
        end
        if (idx < 0) begin
            errors++;
            $display("FAIL %s unexpected event at cycle %0d value %h, required none",
                     kname(kind), cyc, val);
        end else begin
            if (expq[idx].cyc != cyc || expq[idx].val !== val) begin
                errors++;
                $display("FAIL %s got cycle %0d value %h, required cycle %0d value %h",
                         kname(kind), cyc, val, expq[idx].cyc, expq[idx].val);
            end
            expq.delete(idx);
        end
    endtask

    task automatic drain(input string tag);
        foreach (expq[i]) begin
            checks++;
            errors++;
            $display("FAIL %s %s missing, required at cycle %0d value %h (now %0d)",
                     tag, kname(expq[i].kind), expq[i].cyc, expq[i].val, cyc);
        end
        expq.delete();
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (enter_press) observe(K_ENTER, '0);
            if (reset_press) observe(K_RESET, '0);
            if (enter_level !== prev_level) observe(K_LEVEL, {9'b0, enter_level});
            if (sw_sync !== prev_sync) observe(K_SYNC, sw_sync);
            if (sw_delta != '0) observe(K_DELTA, sw_delta);
            if (sec_tick) observe(K_TICK, '0);
        end
        prev_level = enter_level;
        prev_sync  = sw_sync;
    end

    // Called at a negedge; returns at the negedge where rst_n goes high.
    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        if (mon_en && sw_model != '0) push(K_SYNC, cyc + 1, '0);
        repeat (hold) @(negedge clk);
        check("rst_enter_level", {9'b0, enter_level}, '0);
        check("rst_enter_press", {9'b0, enter_press}, '0);
        check("rst_reset_press", {9'b0, reset_press}, '0);
        check("rst_sw_sync", sw_sync, '0);
        check("rst_sw_delta", sw_delta, '0);
        check("rst_sec_tick", {9'b0, sec_tick}, '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        if (sw_model != '0) push(K_SYNC, cyc + 2, sw_model);
    endtask

    task automatic set_sw(input logic [9:0] v);
        sw_raw = v;
        if (v != sw_model) begin
            push(K_SYNC, cyc + 2, v);
            push(K_DELTA, cyc + 3, v ^ sw_model);
        end
        sw_model = v;
    endtask

    initial begin
        int c;
        rst_n       = 1'b0;
        btn_enter_n = 1'b1;
        btn_reset_n = 1'b1;
        tick_clr    = 1'b1;
        sw_raw      = 10'h3FF;
        sw_model    = 10'h3FF;
        @(negedge clk);

        // Reset release with all switches on: sync follows, delta masked.
        apply_reset(3);
        repeat (10) @(negedge clk);
        drain("s1");

        // Clean enter press and release.
        c = cyc;
        btn_enter_n = 1'b0;
        push(K_LEVEL, c + 6, 10'h001);
        push(K_ENTER, c + 7, '0);
        repeat (20) @(negedge clk);
        c = cyc;
        btn_enter_n = 1'b1;
        push(K_LEVEL, c + 6, 10'h000);
        repeat (10) @(negedge clk);
        drain("s2");

        // Bouncing enter never settles long enough.
        btn_enter_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_enter_n = 1'b1;
        @(negedge clk);
        btn_enter_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_enter_n = 1'b1;
        repeat (10) @(negedge clk);
        drain("s3");

        // Switch changes: all off, then two switches on together.
        set_sw(10'h000);
        repeat (6) @(negedge clk);
        set_sw(10'h208);
        repeat (6) @(negedge clk);
        drain("s4");

        // Both buttons together, reset hits during WAIT_DOWN.
        btn_enter_n = 1'b0;
        btn_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        apply_reset(2);
        c = cyc;
        push(K_LEVEL, c + 6, 10'h001);
        push(K_ENTER, c + 7, '0);
        push(K_RESET, c + 7, '0);
        repeat (12) @(negedge clk);
        c = cyc;
        btn_enter_n = 1'b1;
        btn_reset_n = 1'b1;
        push(K_LEVEL, c + 6, 10'h000);
        repeat (10) @(negedge clk);
        drain("s6");

        // Free-running tick, then a clear that lands on the terminal count.
        apply_reset(2);
        tick_clr = 1'b0;
        c = cyc;
        push(K_TICK, c + 4, '0);
        push(K_TICK, c + 13, '0);
        push(K_TICK, c + 18, '0);
        repeat (8) @(negedge clk);
        tick_clr = 1'b1;
        @(negedge clk);
        tick_clr = 1'b0;
        repeat (11) @(negedge clk);
        tick_clr = 1'b1;
        repeat (4) @(negedge clk);
        drain("s5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d, required finish before", cyc);
        $fatal(1);
    end

endmodule
